// File: rtl/d_ff_pet_reset_preset_pkg.sv
// Shared constants for the reset/preset D register family.
package d_ff_pet_reset_preset_pkg;

    localparam int unsigned PRESET_SYNC   = 0;
    localparam int unsigned PRESET_ASYNC  = 1;
    localparam int unsigned DEFAULT_WIDTH = 1;

endpackage

// File: rtl/d_ff_pet_bit_cell.sv
// Single-bit D flop with synchronous reset and a sync or async preset chosen at elaboration.
module d_ff_pet_bit_cell
    import d_ff_pet_reset_preset_pkg::*;
#(
    parameter int unsigned ASYNC_PRESET = PRESET_SYNC,
    parameter logic        PRESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset_in,
    input  logic preset_in,
    input  logic d_in,
    output logic q_out
);

    generate
        if (ASYNC_PRESET == PRESET_ASYNC) begin : g_async
            // Preset is the asynchronous control, so it dominates the clocked reset.
            always_ff @(posedge clk or posedge preset_in) begin
                if (preset_in) begin
                    q_out <= PRESET_VALUE;
                end else if (reset_in) begin
                    q_out <= 1'b0;
                end else begin
                    q_out <= d_in;
                end
            end
        end else begin : g_sync
            always_ff @(posedge clk) begin
                if (reset_in) begin
                    q_out <= 1'b0;
                end else if (preset_in) begin
                    q_out <= PRESET_VALUE;
                end else begin
                    q_out <= d_in;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/d_ff_pet_reset_preset.sv
// WIDTH-bit register with synchronous reset and configurable-mode preset, built from bit cells.
module d_ff_pet_reset_preset
    import d_ff_pet_reset_preset_pkg::*;
#(
    parameter int unsigned       WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned       ASYNC_PRESET = PRESET_SYNC,
    parameter logic [WIDTH-1:0]  PRESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             preset_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_ff_pet_bit_cell #(
            .ASYNC_PRESET (ASYNC_PRESET),
            .PRESET_VALUE (PRESET_VALUE[i])
        ) u_cell (
            .clk       (clk),
            .reset_in  (reset_in),
            .preset_in (preset_in),
            .d_in      (d_in[i]),
            .q_out     (q_out[i])
        );
    end

endmodule

// File: tb/tb_d_ff_pet_reset_preset.sv
// Randomized scoreboard bench covering sync/async preset modes at widths 1 and 8.
module tb_d_ff_pet_reset_preset;

    localparam int         NCYC = 200;
    localparam logic [7:0] PV8  = 8'hA5;

    logic       clk = 1'b0;
    logic       reset_in;
    logic       preset_in;
    logic [7:0] d_in;
    logic [7:0] q_s8, q_a8;
    logic       q_s1, q_a1;

    always #10 clk = ~clk;

    d_ff_pet_reset_preset #(
        .WIDTH (8), .ASYNC_PRESET (0), .PRESET_VALUE (PV8)
    ) dut_s8 (
        .clk (clk), .reset_in (reset_in), .preset_in (preset_in), .d_in (d_in), .q_out (q_s8)
    );

    d_ff_pet_reset_preset #(
        .WIDTH (8), .ASYNC_PRESET (1), .PRESET_VALUE (PV8)
    ) dut_a8 (
        .clk (clk), .reset_in (reset_in), .preset_in (preset_in), .d_in (d_in), .q_out (q_a8)
    );

    d_ff_pet_reset_preset dut_s1 (
        .clk (clk), .reset_in (reset_in), .preset_in (preset_in), .d_in (d_in[0]), .q_out (q_s1)
    );

    d_ff_pet_reset_preset #(
        .ASYNC_PRESET (1)
    ) dut_a1 (
        .clk (clk), .reset_in (reset_in), .preset_in (preset_in), .d_in (d_in[0]), .q_out (q_a1)
    );

    typedef struct {
        logic [7:0] s8;
        logic [7:0] a8;
        logic [7:0] s1;
        logic [7:0] a1;
        int         cyc;
        bit         is_mid;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: value each register should hold.
    logic [7:0] m_s8, m_a8, m_s1, m_a1;

    function automatic logic [7:0] sync_next(input logic r, input logic p,
                                             input logic [7:0] d, input logic [7:0] pv);
        if (r) return 8'h00;
        if (p) return pv;
        return d;
    endfunction

    function automatic logic [7:0] async_next(input logic r, input logic p,
                                              input logic [7:0] d, input logic [7:0] pv);
        if (p) return pv;
        if (r) return 8'h00;
        return d;
    endfunction

    task automatic push(input int cyc, input bit is_mid);
        exp_t e;
        e.s8 = m_s8; e.a8 = m_a8; e.s1 = m_s1; e.a1 = m_a1;
        e.cyc = cyc; e.is_mid = is_mid;
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input int cyc, input bit is_mid,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d (%s): got %h expected %h",
                     name, cyc, is_mid ? "mid" : "edge", act, exp);
        end
    endtask

    initial begin
        #(NCYC * 20 + 1000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_in  = 1'b1;
        preset_in = 1'b0;
        d_in      = 8'h00;
        m_s8 = '0; m_a8 = '0; m_s1 = '0; m_a1 = '0;
        fork
            begin : stim
                bit glitch;
                for (int i = 0; i < NCYC; i++) begin
                    @(posedge clk);
                    m_s8 = sync_next(reset_in, preset_in, d_in, PV8);
                    m_a8 = async_next(reset_in, preset_in, d_in, PV8);
                    m_s1 = sync_next(reset_in, preset_in, {7'b0, d_in[0]}, 8'h01);
                    m_a1 = async_next(reset_in, preset_in, {7'b0, d_in[0]}, 8'h01);
                    push(i, 1'b0);
                    #5;
                    // Mid-cycle data changes must not reach q; a short preset pulse
                    // only matters to the async instances.
                    d_in   = 8'($urandom);
                    glitch = !preset_in && (i == 3 || $urandom_range(3) == 0);
                    if (glitch) begin
                        preset_in = 1'b1;
                        m_a8 = PV8;
                        m_a1 = 8'h01;
                    end
                    push(i, 1'b1);
                    #3;
                    if (glitch) preset_in = 1'b0;
                    #7;
                    if (i < 1) begin
                        reset_in = 1'b1; preset_in = 1'b0;
                    end else if (i == 1) begin
                        reset_in = 1'b1; preset_in = 1'b1;
                    end else if (i == 2) begin
                        reset_in = 1'b0; preset_in = 1'b0;
                    end else begin
                        reset_in  = ($urandom_range(7) == 0);
                        preset_in = ($urandom_range(5) == 0);
                    end
                    d_in = 8'($urandom);
                end
            end
            begin : mon
                exp_t e;
                for (int i = 0; i < 2 * NCYC; i++) begin
                    if (i % 2 == 0) begin
                        @(posedge clk);
                        #1;
                    end else begin
                        #8;
                    end
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty slot %0d: got none expected entry", i);
                    end else begin
                        e = sb.pop_front();
                        cmp("sync_w8",  e.cyc, e.is_mid, q_s8, e.s8);
                        cmp("async_w8", e.cyc, e.is_mid, q_a8, e.a8);
                        cmp("sync_w1",  e.cyc, e.is_mid, {7'b0, q_s1}, e.s1);
                        cmp("async_w1", e.cyc, e.is_mid, {7'b0, q_a1}, e.a1);
                    end
                end
            end
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_ff_pet_reset_preset.md
# d_ff_pet_reset_preset

Positive-edge-triggered D register, parameterizable width, with synchronous active-high reset and a preset input. Preset is either synchronous or asynchronous, fixed at elaboration time. One block replaces the separate synchronous and asynchronous preset flip-flop variants. It is a leaf storage primitive instantiated wherever a clean-reset, forced-set register is needed.

## Interface

Parameters:
- WIDTH, 1: data width in bits.
- ASYNC_PRESET, 0: 0 = preset sampled on clk rising edge; 1 = preset acts asynchronously.
- PRESET_VALUE, all ones ({WIDTH{1'b1}}): value loaded by preset.

Ports:
- clk  input  1  single clock; all sampling on rising edge.
- reset_in  input  1  reset is synchronous and active-high; clears q_out.
- preset_in  input  1  active-high preset; forces q_out to PRESET_VALUE.
- d_in  input  WIDTH  data input.
- q_out  output  WIDTH  registered output.

## Operation

- Power-up value of q_out is undefined until the first rising edge with reset_in=1 or preset_in=1.
- Priority with ASYNC_PRESET=0 (all evaluated at clk rising edge):
  - reset_in=1 gives q_out<=0.
  - Otherwise preset_in=1 gives q_out<=PRESET_VALUE.
  - Otherwise q_out<=d_in.
- Priority with ASYNC_PRESET=1:
  - preset_in=1 forces q_out=PRESET_VALUE immediately, without waiting for a clock, and holds it while asserted.
  - Preset overrides reset, because the asynchronous control dominates.
  - With preset_in=0: at the rising edge, reset_in=1 gives q_out<=0; otherwise q_out<=d_in.
  - On preset_in deassertion, q_out keeps PRESET_VALUE until the next rising edge.
- Reset value of q_out is all zeros.
- No enable; the register loads every edge.
- Bits are independent; there is no arithmetic.

## Timing

- Latency: d_in to q_out is 1 clock, visible after the rising edge.
- Sync mode:
  - reset_in and preset_in take effect only at a rising edge.
  - A pulse between edges has no effect.
  - Assert and deassert are both edge-aligned.
- Async mode, preset:
  - Assertion propagates combinationally to q_out within the same delta/timestep.
  - Release is asynchronous; the first data load occurs at the following rising edge.
- Reset assertion mid-operation clears q_out at the next edge only. Data captured before that edge stays visible until then.
- Simultaneous reset_in=1 and preset_in=1:
  - Sync mode: q_out=0.
  - Async mode: q_out=PRESET_VALUE.
- d_in changing between edges has no effect on q_out.

## Structure

- Shared package: mode constants PRESET_SYNC=0 and PRESET_ASYNC=1, and a default-width constant.
- One natural sub-module, d_ff_pet_bit_cell: single-bit cell taking ASYNC_PRESET and a 1-bit preset value.
  - The top uses a generate loop to instantiate WIDTH cells.
  - Each cell receives PRESET_VALUE[i].
- The mode is selected by a generate-if inside the cell: a sync always block versus an async-preset always block sensitive to posedge clk and posedge preset_in.

## Test plan

- Setup for all scenarios: clk period 20 ns; d_in toggles every 7 ns.
- Scenario 1, reset then release, WIDTH=1, sync mode. Hold reset_in=1 with preset_in=0 for 2 edges -> q_out=0. Release reset -> q_out tracks d_in sampled at each edge, 1-cycle latency.
- Scenario 2, preset window, sync mode. reset_in=1 until t=30; preset_in=1 until t=80 -> q_out=0 after the first edge, q_out=1 at edges between 30 and 80, then follows d_in.
- Scenario 3, simultaneous reset_in=1 and preset_in=1.
  - Sync mode -> q_out=0 at the edge.
  - Async mode -> q_out=1 immediately, held while preset is asserted.
- Scenario 4, async preset between edges. ASYNC_PRESET=1; pulse preset_in at t=5 (clk low) -> q_out=1 at t=5 without a clock. After release, q_out stays 1 until the next edge loads d_in.
- Scenario 5, sync preset glitch. ASYNC_PRESET=0; a preset_in pulse not spanning any rising edge -> q_out unchanged.
- Scenario 6, wide register. WIDTH=8, PRESET_VALUE=8'hA5; preset at an edge -> q_out=8'hA5; reset -> 8'h00; d_in=8'h3C -> q_out=8'h3C one cycle later.
